// File: rtl/lcms_pkg.sv
// Shared definitions for the LCMS VCMD sweep generator: FSM encoding,
// DAC full-scale constant and the clamped step arithmetic.
package lcms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } sweep_state_e;

  localparam logic [15:0] DAC_FULL_SCALE = 16'hFFFF;

  // Widened to 17 bits so codes near full scale cannot wrap past hi.
  function automatic logic [15:0] step_up(input logic [15:0] v,
                                          input logic [15:0] s,
                                          input logic [15:0] hi);
    logic [16:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return (sum > {1'b0, hi}) ? hi : sum[15:0];
  endfunction

  // Bit 16 of the difference flags a borrow, i.e. the result went negative.
  function automatic logic [15:0] step_down(input logic [15:0] v,
                                            input logic [15:0] s,
                                            input logic [15:0] lo);
    logic [16:0] diff;
    diff = {1'b0, v} - {1'b0, s};
    return (diff[16] || (diff[15:0] < lo)) ? lo : diff[15:0];
  endfunction

endpackage

// File: rtl/lcms_vcmd_sweep_gen_if.sv
// Control bundle between the sweep FSM and its dwell timer.
interface lcms_vcmd_sweep_gen_if #(
  parameter int DW = 16
);
  logic          load;
  logic          count_en;
  logic [DW-1:0] load_val;
  logic          expired;

  modport master (output load, output count_en, output load_val, input expired);
  modport slave  (input load, input count_en, input load_val, output expired);
endinterface

// File: rtl/lcms_dwell_timer.sv
// Dwell down-counter: load with the hold length, expiry flagged on the
// last clock of the hold so the next code lands exactly on time.
module lcms_dwell_timer #(
  parameter int DW = 16
) (
  input logic                  clk,
  input logic                  rst,
  lcms_vcmd_sweep_gen_if.slave tmr
);
  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tmr.load) begin
      cnt_d = tmr.load_val;
    end else if (tmr.count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmr.expired = tmr.count_en && (cnt_q == ONE);
endmodule

// File: rtl/lcms_vcmd_sweep_gen.sv
// Triangle sweep of the DAC command code between latched bounds, with
// per-code dwell, cycle counting, abort and rejected-start flagging.
module lcms_vcmd_sweep_gen
  import lcms_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NCW = 8
) (
  input  logic            dac_sm_clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [15:0]     v_low_i,
  input  logic [15:0]     v_high_i,
  input  logic [15:0]     step_i,
  input  logic [DW-1:0]   dwell_i,
  input  logic [NCW-1:0]  n_cycles_i,
  input  logic [15:0]     v_hold_i,
  output logic [15:0]     VCMD,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [NCW-1:0]  cycle_cnt_o
);
  localparam logic [DW-1:0]  DW_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [NCW-1:0] NC_ONE = {{(NCW-1){1'b0}}, 1'b1};

  sweep_state_e   state_q, state_d;
  logic [15:0]    vcmd_q, vcmd_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NCW-1:0] cyc_q, cyc_d, cyc_inc;
  logic [15:0]    vlow_q, vlow_d, vhigh_q, vhigh_d, step_q, step_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [NCW-1:0] ncyc_q, ncyc_d;

  lcms_vcmd_sweep_gen_if #(.DW(DW)) tmr_if ();

  lcms_dwell_timer #(.DW(DW)) u_dwell (
    .clk (dac_sm_clk),
    .rst (reset),
    .tmr (tmr_if.slave)
  );

  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + NC_ONE;

  always_comb begin
    state_d         = state_q;
    vcmd_d          = vcmd_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = err_q;
    cyc_d           = cyc_q;
    vlow_d          = vlow_q;
    vhigh_d         = vhigh_q;
    step_d          = step_q;
    dwell_d         = dwell_q;
    ncyc_d          = ncyc_q;
    tmr_if.load     = 1'b0;
    tmr_if.load_val = dwell_q;
    tmr_if.count_en = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        vcmd_d = v_hold_i;
        if (start_i && !stop_i) begin
          if (v_low_i < v_high_i) begin
            vlow_d          = v_low_i;
            vhigh_d         = v_high_i;
            step_d          = (step_i == '0) ? 16'd1 : step_i;
            dwell_d         = (dwell_i == '0) ? DW_ONE : dwell_i;
            ncyc_d          = n_cycles_i;
            cyc_d           = '0;
            err_d           = 1'b0;
            vcmd_d          = v_low_i;
            busy_d          = 1'b1;
            state_d         = ST_UP;
            tmr_if.load     = 1'b1;
            tmr_if.load_val = (dwell_i == '0) ? DW_ONE : dwell_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          vcmd_d  = v_hold_i;
        end else if (tmr_if.expired) begin
          tmr_if.load = 1'b1;
          if (vcmd_q == vhigh_q) begin
            state_d = ST_DOWN;
            vcmd_d  = step_down(vcmd_q, step_q, vlow_q);
          end else begin
            vcmd_d  = step_up(vcmd_q, step_q, vhigh_q);
          end
        end
      end

      ST_DOWN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          vcmd_d  = v_hold_i;
        end else if (tmr_if.expired) begin
          if (vcmd_q > vlow_q) begin
            tmr_if.load = 1'b1;
            vcmd_d      = step_down(vcmd_q, step_q, vlow_q);
          end else begin
            cyc_d = cyc_inc;
            if ((ncyc_q != '0) && (cyc_inc == ncyc_q)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
              vcmd_d  = v_hold_i;
            end else begin
              // Turn-around at the bottom: v_low is not held a second time.
              tmr_if.load = 1'b1;
              vcmd_d      = step_up(vlow_q, step_q, vhigh_q);
              state_d     = ST_UP;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dac_sm_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vcmd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      vlow_q  <= '0;
      vhigh_q <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      ncyc_q  <= '0;
    end else begin
      state_q <= state_d;
      vcmd_q  <= vcmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      vlow_q  <= vlow_d;
      vhigh_q <= vhigh_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      ncyc_q  <= ncyc_d;
    end
  end

  assign VCMD        = vcmd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cycle_cnt_o = cyc_q;
endmodule

// File: tb/tb_lcms_vcmd_sweep_gen.sv
// Directed and randomized bench for lcms_vcmd_sweep_gen; expected code
// trajectories come from a list-based triangle model.
module tb_lcms_vcmd_sweep_gen;
  localparam int DW  = 16;
  localparam int NCW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i, stop_i;
  logic [15:0]    v_low_i, v_high_i, step_i, v_hold_i;
  logic [DW-1:0]  dwell_i;
  logic [NCW-1:0] n_cycles_i;
  logic [15:0]    VCMD;
  logic           busy_o, done_o, err_o;
  logic [NCW-1:0] cycle_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  lcms_vcmd_sweep_gen #(.DW(DW), .NCW(NCW)) dut (
    .dac_sm_clk  (clk),
    .reset       (rst),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .v_low_i     (v_low_i),
    .v_high_i    (v_high_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .n_cycles_i  (n_cycles_i),
    .v_hold_i    (v_hold_i),
    .VCMD        (VCMD),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected VCMD for every clock from the start edge to the last held code.
  task automatic build_ref(input int vl, input int vh, input int s, input int d, input int n);
    int v;
    exp_q.delete();
    if (s == 0) s = 1;
    if (d == 0) d = 1;
    for (int r = 0; r < d; r++) exp_q.push_back(vl);
    for (int c = 0; c < n; c++) begin
      v = vl;
      while (v < vh) begin
        v = (v + s > vh) ? vh : v + s;
        for (int r = 0; r < d; r++) exp_q.push_back(v);
      end
      while (v > vl) begin
        v = (v - s < vl) ? vl : v - s;
        for (int r = 0; r < d; r++) exp_q.push_back(v);
      end
    end
  endtask

  task automatic set_params(input int vl, input int vh, input int s, input int d, input int n);
    v_low_i    = 16'(vl);
    v_high_i   = 16'(vh);
    step_i     = 16'(s);
    dwell_i    = DW'(d);
    n_cycles_i = NCW'(n);
  endtask

  task automatic run_sweep(input string tag, input int vl, input int vh, input int s,
                           input int d, input int n, input bit disturb);
    set_params(vl, vh, s, d, n);
    build_ref(vl, vh, s, d, n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    if (disturb) begin
      v_low_i    = 16'($urandom);
      v_high_i   = 16'($urandom);
      step_i     = 16'($urandom);
      dwell_i    = DW'($urandom);
      n_cycles_i = NCW'($urandom);
      v_hold_i   = 16'($urandom);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        start_i = disturb && (k == 2);
        tick();
        start_i = 1'b0;
      end
      check($sformatf("%s vcmd[%0d]", tag, k), 32'(VCMD), 32'(exp_q[k]));
      check($sformatf("%s busy[%0d]", tag, k), 32'(busy_o), 32'd1);
    end
    tick();
    check({tag, " done"}, 32'(done_o), 32'd1);
    check({tag, " busy_end"}, 32'(busy_o), 32'd0);
    check({tag, " cycles"}, 32'(cycle_cnt_o), 32'(n));
    tick();
    check({tag, " done_pulse"}, 32'(done_o), 32'd0);
    check({tag, " hold"}, 32'(VCMD), 32'(v_hold_i));
  endtask

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    set_params(0, 0, 0, 0, 0);
    v_hold_i = 16'h0ABC;

    #12;
    check("rst vcmd", 32'(VCMD), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst cycles", 32'(cycle_cnt_o), 32'd0);
    #11 rst = 1'b0;
    tick();
    check("post_rst hold", 32'(VCMD), 32'h0ABC);

    run_sweep("dwell2", 100, 110, 5, 2, 1, 1'b0);
    run_sweep("clamp7", 100, 110, 7, 1, 1, 1'b0);
    run_sweep("top", 16'hFFF0, 16'hFFFF, 16'h8000, 1, 1, 1'b0);

    // Rejected start, then a valid start clears the flag.
    v_hold_i = 16'h1234;
    set_params(200, 200, 5, 2, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("rej err", 32'(err_o), 32'd1);
    check("rej busy", 32'(busy_o), 32'd0);
    check("rej vcmd", 32'(VCMD), 32'h1234);
    tick();
    check("rej sticky", 32'(err_o), 32'd1);
    set_params(100, 110, 5, 2, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("acc err", 32'(err_o), 32'd0);
    check("acc busy", 32'(busy_o), 32'd1);
    check("acc vcmd", 32'(VCMD), 32'd100);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("acc stop busy", 32'(busy_o), 32'd0);
    check("acc stop done", 32'(done_o), 32'd0);

    // n=0, dwell=0, then stop with start in the same cycle.
    v_hold_i = 16'h0555;
    set_params(10, 20, 3, 0, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("ss vcmd0", 32'(VCMD), 32'd10);
    tick();
    check("ss vcmd1", 32'(VCMD), 32'd13);
    tick();
    check("ss vcmd2", 32'(VCMD), 32'd16);
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("ss busy", 32'(busy_o), 32'd0);
    check("ss done", 32'(done_o), 32'd0);
    tick();
    check("ss idle busy", 32'(busy_o), 32'd0);
    check("ss idle done", 32'(done_o), 32'd0);
    check("ss idle vcmd", 32'(VCMD), 32'h0555);

    // Endless sweep: cycle count saturates and the sweep keeps running.
    set_params(0, 1, 1, 1, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (600) tick();
    check("sat cycles", 32'(cycle_cnt_o), 32'd255);
    check("sat busy", 32'(busy_o), 32'd1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("sat stop busy", 32'(busy_o), 32'd0);
    check("sat stop done", 32'(done_o), 32'd0);
    check("sat stop cycles", 32'(cycle_cnt_o), 32'd255);

    for (int t = 0; t < 20; t++) begin
      int range, base;
      range    = $urandom_range(1, 40);
      base     = $urandom_range(0, 65535 - range);
      v_hold_i = 16'($urandom);
      run_sweep($sformatf("rnd%0d", t), base, base + range, $urandom_range(0, 12),
                $urandom_range(0, 3), $urandom_range(1, 3), t[0]);
    end

    // Asynchronous reset in the second cycle's descent.
    v_hold_i = 16'h0777;
    set_params(100, 110, 5, 3, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (22) tick();
    check("arst pre vcmd", 32'(VCMD), 32'd105);
    check("arst pre cycles", 32'(cycle_cnt_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst vcmd", 32'(VCMD), 32'd0);
    check("arst busy", 32'(busy_o), 32'd0);
    check("arst cycles", 32'(cycle_cnt_o), 32'd0);
    check("arst done", 32'(done_o), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("arst hold", 32'(VCMD), 32'h0777);
    check("arst idle busy", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcms_vcmd_sweep_gen.md
LCMS_VCMD_SWEEP_GEN -- requirements
Module: lcms_vcmd_sweep_gen

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the width of the dwell counter and of dwell_i.
REQ-002 The block SHALL have parameter NCW, default 8, meaning the width of the cycle counter and of n_cycles_i.
REQ-003 The block SHALL have port dac_sm_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start_i, input, 1 bit: single-cycle sweep request.
REQ-006 The block SHALL have port stop_i, input, 1 bit: single-cycle abort request.
REQ-007 The block SHALL have port v_low_i, input, 16 bits: sweep lower bound, DAC code.
REQ-008 The block SHALL have port v_high_i, input, 16 bits: sweep upper bound, DAC code.
REQ-009 The block SHALL have port step_i, input, 16 bits: code increment per step.
REQ-010 The block SHALL have port dwell_i, input, DW bits: clocks each code is held.
REQ-011 The block SHALL have port n_cycles_i, input, NCW bits: full triangle cycles to run; 0 means run until stop.
REQ-012 The block SHALL have port v_hold_i, input, 16 bits: code driven while idle.
REQ-013 The block SHALL have port VCMD, output, 16 bits: registered command code, consumed by the configuration block's VCMD input.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high while a sweep is running.
REQ-015 The block SHALL have port done_o, output, 1 bit: one-cycle pulse on normal completion.
REQ-016 The block SHALL have port err_o, output, 1 bit: sticky flag for a rejected start (v_low_i >= v_high_i); cleared by the next accepted start.
REQ-017 The block SHALL have port cycle_cnt_o, output, NCW bits: number of completed cycles.

Function
REQ-018 The FSM SHALL have states IDLE, UP and DOWN.
REQ-019 IDLE SHALL load VCMD <= v_hold_i every cycle.
REQ-020 In IDLE, a start_i with v_low_i < v_high_i SHALL latch all parameters.
REQ-021 An accepted start SHALL substitute dwell 0 with 1 and step 0 with 1.
REQ-022 An accepted start SHALL clear cycle_cnt_o, clear err_o, set VCMD <= v_low, set busy_o and enter UP.
REQ-023 A start_i in IDLE with v_low_i >= v_high_i SHALL set err_o and remain in IDLE.
REQ-024 Each VCMD value during a sweep SHALL be held for exactly dwell clocks; the dwell counter reloads on every code change.
REQ-025 On dwell expiry in UP, VCMD SHALL become min(VCMD+step, v_high), computed 17-bit with no wrap.
REQ-026 On dwell expiry in UP with VCMD == v_high, the FSM SHALL enter DOWN and VCMD SHALL become max(VCMD-step, v_low), computed 17-bit signed with no underflow.
REQ-027 On dwell expiry in DOWN with VCMD > v_low, VCMD SHALL step down as in REQ-026.
REQ-028 On dwell expiry in DOWN with VCMD == v_low, cycle_cnt_o SHALL increment.
REQ-029 If the incremented count equals n_cycles (n_cycles != 0), the block SHALL pulse done_o, clear busy_o and enter IDLE.
REQ-030 Otherwise, on the same edge as REQ-028, VCMD SHALL become min(v_low+step, v_high) and the FSM SHALL enter UP; v_low is not re-held.
REQ-031 With n_cycles == 0, cycle_cnt_o SHALL saturate at all-ones and the sweep SHALL continue.
REQ-032 stop_i in UP or DOWN SHALL enter IDLE on the next edge, clear busy_o and leave done_o low.
REQ-033 stop_i and start_i asserted in the same cycle SHALL act as stop.
REQ-034 start_i while busy SHALL be ignored.
REQ-035 Parameter input changes mid-sweep SHALL have no effect.

Reset
REQ-036 Reset SHALL force IDLE, VCMD=0, busy_o=0, done_o=0, err_o=0, cycle_cnt_o=0, dwell counter=0 and latched parameters=0, immediately and regardless of the clock.
REQ-037 Reset asserted mid-sweep SHALL abort the sweep with no done_o pulse.
REQ-038 The first action after reset deassertion SHALL be VCMD <= v_hold_i.

Structure
REQ-039 The state encoding and DAC_FULL_SCALE (16'hFFFF) SHALL reside in the shared package lcms_pkg.
REQ-040 The dwell counter SHALL be the sub-module lcms_dwell_timer (load, count, expiry pulse).
REQ-041 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-042 The bench SHALL drive v_low=100, v_high=110, step=5, dwell=2, n=1 and check VCMD = 100,100,105,105,110,110,105,105,100,100, then a done_o pulse and busy_o low.
REQ-043 The bench SHALL drive step=7 with the bounds of REQ-042, dwell=1, n=1 and check VCMD = 100,107,110,103,100 (clamped at both ends).
REQ-044 The bench SHALL drive v_low=16'hFFF0, v_high=16'hFFFF, step=16'h8000 and check that VCMD reaches 16'hFFFF with no wrap, then returns to 16'hFFF0.
REQ-045 The bench SHALL drive v_low=200, v_high=200 and check err_o=1, busy_o=0 and VCMD=v_hold_i; it SHALL then issue a valid start and check that err_o clears.
REQ-046 The bench SHALL drive n=0 and dwell=0, issue stop_i after 3 cycles with start_i asserted in the same cycle, and check: each code held 1 clock, IDLE entered, no done_o pulse.
REQ-047 The bench SHALL assert reset asynchronously mid-DOWN and check that VCMD=0, busy_o=0 and cycle_cnt_o=0 before the next clock edge.
